// File: rtl/srcnn_mul_share_arb_if.sv
// ---------------------------------------------------------------------------
// srcnn_mul_share_arb_if
// Handshake bundle between the SRCNN layer engines (requesters) and the
// shared-multiplier arbiter.
//   req_valid/req_ready : per-requester operand handshake (bit i = requester i)
//   req_a/req_b         : packed operands, requester i at [i*W +: W]
//   res_valid/res_ready : single product handshake
//   res_data/res_id     : product and owning requester index
//   busy                : any pipeline stage occupied
// slave  = arbiter view, master = engine/consumer view.
// ---------------------------------------------------------------------------
interface srcnn_mul_share_arb_if #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 9,
  parameter int B_WIDTH  = 9,
  parameter int P_WIDTH  = 18,
  parameter int ID_WIDTH = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       res_valid;
  logic                       res_ready;
  logic [P_WIDTH-1:0]         res_data;
  logic [ID_WIDTH-1:0]        res_id;
  logic                       busy;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/srcnn_mul_share_arb.sv
// ---------------------------------------------------------------------------
// srcnn_mul_share_arb
// Round-robin arbiter feeding one shared unsigned A_WIDTH x B_WIDTH multiplier
// through a 2-stage pipeline (S1 operand register, S2 result register).
// Ports:
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset
//   bus      : srcnn_mul_share_arb_if.slave (operand requests, tagged product)
// ---------------------------------------------------------------------------

// Per-requester grant decision. A requester wins when it is valid and no
// valid requester sits closer to the round-robin start point (last+1).
module srcnn_mul_share_arb_lane #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int IDX      = 0
) (
  input  logic [NUM_REQ-1:0]  valid_i,
  input  logic [ID_WIDTH-1:0] last_i,
  output logic                gnt_o
);
  int my_dist;
  int d;

  always_comb begin
    gnt_o   = valid_i[IDX];
    // distance from the first-priority slot, wrapping modulo NUM_REQ
    my_dist = (IDX + 2*NUM_REQ - int'(last_i) - 1) % NUM_REQ;
    d       = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j + 2*NUM_REQ - int'(last_i) - 1) % NUM_REQ;
      if (valid_i[j] && (d < my_dist)) gnt_o = 1'b0;
    end
  end
endmodule

module srcnn_mul_share_arb #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 9,
  parameter int B_WIDTH  = 9,
  parameter int P_WIDTH  = 18,
  parameter int ID_WIDTH = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  srcnn_mul_share_arb_if.slave    bus
);
  // pointer and pipeline state
  logic [ID_WIDTH-1:0] last_q;
  logic                s1_valid_q;
  logic [A_WIDTH-1:0]  s1_a_q;
  logic [B_WIDTH-1:0]  s1_b_q;
  logic [ID_WIDTH-1:0] s1_id_q;
  logic                res_valid_q;
  logic [P_WIDTH-1:0]  res_data_q;
  logic [ID_WIDTH-1:0] res_id_q;

  logic                s2_en, s1_en;
  logic [NUM_REQ-1:0]  gnt_raw, gnt;
  logic [ID_WIDTH-1:0] gnt_id;
  logic [A_WIDTH-1:0]  a_sel;
  logic [B_WIDTH-1:0]  b_sel;
  logic [P_WIDTH-1:0]  prod_d;

  assign s2_en = !res_valid_q || bus.res_ready;
  assign s1_en = !s1_valid_q || s2_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      srcnn_mul_share_arb_lane #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH),
        .IDX      (gi)
      ) u_lane (
        .valid_i (bus.req_valid),
        .last_i  (last_q),
        .gnt_o   (gnt_raw[gi])
      );
    end
  endgenerate

  // No grant while S1 cannot advance; the reset term keeps req_ready low
  // during reset even though the grant path is purely combinational.
  assign gnt = gnt_raw & {NUM_REQ{s1_en & ap_rst_n}};

  // one-hot grant -> index and operand mux
  always_comb begin
    gnt_id = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_id = ID_WIDTH'(i);
        a_sel  = bus.req_a[i*A_WIDTH +: A_WIDTH];
        b_sel  = bus.req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // zero-extend both operands so the product keeps all P_WIDTH bits
  assign prod_d = P_WIDTH'(s1_a_q) * P_WIDTH'(s1_b_q);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      last_q      <= ID_WIDTH'(NUM_REQ-1);
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= |gnt;
        if (|gnt) begin
          s1_a_q  <= a_sel;
          s1_b_q  <= b_sel;
          s1_id_q <= gnt_id;
          last_q  <= gnt_id;
        end
      end
      if (s2_en) begin
        res_valid_q <= s1_valid_q;
        res_data_q  <= prod_d;
        res_id_q    <= s1_id_q;
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = s1_valid_q | res_valid_q;
endmodule

// File: tb/tb_srcnn_mul_share_arb.sv
// ---------------------------------------------------------------------------
// tb_srcnn_mul_share_arb
// Scoreboard bench: stimulus pushes expected {id, product}, a negedge monitor
// pops on every result handshake and also tracks a small occupancy /
// round-robin model to check req_ready, res_valid, busy and fairness.
// ---------------------------------------------------------------------------
module tb_srcnn_mul_share_arb;
  localparam int NR = 4, AW = 9, BW = 9, PW = 18, IW = 2;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  srcnn_mul_share_arb_if #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW),
                           .P_WIDTH(PW), .ID_WIDTH(IW)) bus ();

  srcnn_mul_share_arb #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW),
                        .P_WIDTH(PW), .ID_WIDTH(IW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  logic [AW-1:0] a_op [NR];
  logic [BW-1:0] b_op [NR];

  always_comb begin
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*AW +: AW] = a_op[i];
      bus.req_b[i*BW +: BW] = b_op[i];
    end
  end

  typedef struct { int id; int data; } exp_t;
  exp_t sb [$];

  int total = 0;
  int bad   = 0;
  bit auto_push = 1'b0;

  // reference model state
  int            m_last = NR-1;
  bit            m_s1 = 1'b0, m_s2 = 1'b0;
  logic [NR-1:0] m_acc = '0;
  int            waits [NR];
  bit            have_hold = 1'b0;
  logic [PW-1:0] h_data;
  logic [IW-1:0] h_id;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // monitor / model, evaluated away from the active edge
  always @(negedge ap_clk) begin : mon
    logic [NR-1:0] er;
    bit s2en, s1en;
    int gid, mx;
    exp_t e;
    if (!ap_rst_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_busy", bus.busy, 0);
      m_s1 = 1'b0; m_s2 = 1'b0; m_last = NR-1; m_acc = '0;
      have_hold = 1'b0;
      sb.delete();
      for (int i = 0; i < NR; i++) waits[i] = 0;
    end else begin
      s2en = !m_s2 || bus.res_ready;
      s1en = !m_s1 || s2en;
      er = '0; gid = -1;
      if (s1en)
        for (int k = 1; k <= NR; k++)
          if (gid < 0 && bus.req_valid[(m_last + k) % NR]) gid = (m_last + k) % NR;
      if (gid >= 0) er[gid] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      chk("res_valid", bus.res_valid, m_s2);
      chk("busy", bus.busy, m_s1 | m_s2);
      if (have_hold) begin
        chk("hold_data", bus.res_data, h_data);
        chk("hold_id", bus.res_id, h_id);
      end
      have_hold = bus.res_valid && !bus.res_ready;
      h_data = bus.res_data;
      h_id   = bus.res_id;
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result actual_id=%0d actual_data=%0d expected=none",
                   bus.res_id, bus.res_data);
        end else begin
          e = sb.pop_front();
          chk("res_data", bus.res_data, e.data);
          chk("res_id", bus.res_id, e.id);
        end
      end
      if (gid >= 0) begin
        mx = 0;
        for (int i = 0; i < NR; i++) begin
          if (i == gid || !bus.req_valid[i]) waits[i] = 0;
          else waits[i]++;
          if (waits[i] > mx) mx = waits[i];
        end
        chk("fair_wait_le_3", (mx <= NR-1), 1);
        if (auto_push) sb.push_back('{gid, int'(a_op[gid]) * int'(b_op[gid])});
        m_last = gid;
      end
      m_acc = er;
      if (s2en) m_s2 = m_s1;
      if (s1en) m_s1 = (gid >= 0);
    end
  end

  // advance one cycle; accepted requesters drop valid
  task automatic tick_dir(output int n);
    @(posedge ap_clk); #1;
    n = $countones(m_acc);
    bus.req_valid = bus.req_valid & ~m_acc;
  endtask

  initial begin
    int n, acc;
    bit r0_second;
    logic [15:0] lfsr;
    lfsr = 16'hACE1;
    ap_rst_n = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin a_op[i] = '0; b_op[i] = '0; waits[i] = 0; end

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_id", bus.res_id, 0);
    ap_rst_n = 1'b1;

    // single request: 3*5
    a_op[0] = 9'd3; b_op[0] = 9'd5;
    sb.push_back('{0, 15});
    bus.req_valid = 4'b0001;
    repeat (6) tick_dir(n);

    // extremes: r1 0*511, r2 511*511 (last=0 -> r1 first)
    a_op[1] = 9'd0;   b_op[1] = 9'd511;
    a_op[2] = 9'd511; b_op[2] = 9'd511;
    sb.push_back('{1, 0});
    sb.push_back('{2, 261121});
    bus.req_valid = 4'b0110;
    repeat (6) tick_dir(n);

    // all four once (last=2 -> order 3,0,1,2)
    a_op[0] = 9'd10;  b_op[0] = 9'd20;
    a_op[1] = 9'd7;   b_op[1] = 9'd9;
    a_op[2] = 9'd100; b_op[2] = 9'd3;
    a_op[3] = 9'd12;  b_op[3] = 9'd12;
    sb.push_back('{3, 144});
    sb.push_back('{0, 200});
    sb.push_back('{1, 63});
    sb.push_back('{2, 300});
    bus.req_valid = 4'b1111;
    repeat (8) tick_dir(n);

    // backpressure: consumer stalled, only two operands fit
    bus.res_ready = 1'b0;
    a_op[1] = 9'd5; b_op[1] = 9'd6;
    a_op[2] = 9'd8; b_op[2] = 9'd9;
    sb.push_back('{1, 30});
    sb.push_back('{2, 72});
    bus.req_valid = 4'b0110;
    acc = 0;
    repeat (5) begin tick_dir(n); acc += n; end
    chk("bp_accepted", acc, 2);
    a_op[0] = 9'd4; b_op[0] = 9'd4;
    sb.push_back('{0, 16});
    bus.req_valid = 4'b0001;
    acc = 0;
    repeat (2) begin tick_dir(n); acc += n; end
    chk("bp_no_accept_full", acc, 0);
    bus.res_ready = 1'b1;
    repeat (6) tick_dir(n);
    chk("bp_drained", sb.size(), 0);

    // churn: requester 3 always valid, others and consumer toggling
    auto_push = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge ap_clk); #1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      for (int i = 0; i < NR; i++)
        if (m_acc[i]) begin
          a_op[i] = lfsr[8:0] ^ AW'(i * 37);
          b_op[i] = lfsr[15:7];
        end
      bus.req_valid = {1'b1, lfsr[2:0]};
      bus.res_ready = lfsr[5] | lfsr[6];
    end

    // async reset in the middle of a cycle
    @(posedge ap_clk); #3;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_res_valid", bus.res_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    chk("arst_res_data", bus.res_data, 0);
    chk("arst_res_id", bus.res_id, 0);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    auto_push = 1'b0;
    @(posedge ap_clk);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;

    // after reset: grant order 0,1,2,3,0
    a_op[0] = 9'd2; b_op[0] = 9'd3;
    a_op[1] = 9'd4; b_op[1] = 9'd5;
    a_op[2] = 9'd6; b_op[2] = 9'd7;
    a_op[3] = 9'd8; b_op[3] = 9'd9;
    sb.push_back('{0, 6});
    sb.push_back('{1, 20});
    sb.push_back('{2, 42});
    sb.push_back('{3, 72});
    sb.push_back('{0, 511});
    bus.req_valid = 4'b1111;
    r0_second = 1'b0;
    repeat (10) begin
      @(posedge ap_clk); #1;
      if (m_acc[0] && !r0_second) begin
        a_op[0] = 9'd511; b_op[0] = 9'd1;
        r0_second = 1'b1;
      end else begin
        bus.req_valid = bus.req_valid & ~m_acc;
      end
    end
    chk("final_drained", sb.size(), 0);
    chk("final_idle_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
